// File: rtl/rf_writeback_if.sv
// Result/reservation/hazard bundle between EXU, LSU, decode and the
// register-file writeback stage.
interface rf_writeback_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic                  issue_ready;

  logic                  exu_valid;
  logic                  exu_ready;
  logic [ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_data;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  logic [ADDR_WIDTH-1:0] chk_addr1;
  logic [ADDR_WIDTH-1:0] chk_addr2;
  logic                  chk_busy1;
  logic                  chk_busy2;

  logic                  err;

  modport master (
    output issue_valid, issue_rd,
    input  issue_ready,
    output exu_valid, exu_rd, exu_data,
    input  exu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    output chk_addr1, chk_addr2,
    input  chk_busy1, chk_busy2,
    input  err
  );

  modport slave (
    input  issue_valid, issue_rd,
    output issue_ready,
    input  exu_valid, exu_rd, exu_data,
    output exu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output rf_wen, rf_waddr, rf_wdata,
    input  chk_addr1, chk_addr2,
    output chk_busy1, chk_busy2,
    output err
  );
endinterface

// File: rtl/rf_writeback.sv
// Serializes EXU/LSU results onto the register-file write port and
// tracks pending writes per register for decode hazard checks.
module rf_writeback #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  rf_writeback_if.slave bus
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [1:0]            cnt [NREG];

  logic                  acc;
  logic [ADDR_WIDTH-1:0] acc_rd;
  logic [DATA_WIDTH-1:0] acc_data;

  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;

  logic                  issue_ok;
  logic                  issue_fire;
  logic                  unres;

  // LSU has fixed priority; it is always accepted.
  assign bus.lsu_ready = 1'b1;
  assign bus.exu_ready = ~bus.lsu_valid;

  always_comb begin
    acc      = 1'b0;
    acc_rd   = '0;
    acc_data = '0;
    priority case (1'b1)
      bus.lsu_valid: begin
        acc      = 1'b1;
        acc_rd   = bus.lsu_rd;
        acc_data = bus.lsu_data;
      end
      bus.exu_valid: begin
        acc      = 1'b1;
        acc_rd   = bus.exu_rd;
        acc_data = bus.exu_data;
      end
      default: begin
        acc      = 1'b0;
      end
    endcase
  end

  assign issue_ok = (bus.issue_rd == '0)
                  | (cnt[bus.issue_rd] != 2'd3);
  assign issue_fire = bus.issue_valid & issue_ok
                    & (bus.issue_rd != '0);
  assign bus.issue_ready = issue_ok;

  assign bus.chk_busy1 = (bus.chk_addr1 != '0)
                       & (cnt[bus.chk_addr1] != 2'd0);
  assign bus.chk_busy2 = (bus.chk_addr2 != '0)
                       & (cnt[bus.chk_addr2] != 2'd0);

  // Write stage: one cycle from accept to the register-file port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= acc & (acc_rd != '0);
      if (acc) begin
        waddr_q <= acc_rd;
        wdata_q <= acc_data;
      end
    end
  end

  assign bus.rf_wen   = wen_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;

  // Busy holds through the write cycle; the retire edge drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= 2'd0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (issue_fire && bus.issue_rd == ADDR_WIDTH'(i)
            && !(wen_q && waddr_q == ADDR_WIDTH'(i))) begin
          cnt[i] <= cnt[i] + 2'd1;
        end else if (wen_q && waddr_q == ADDR_WIDTH'(i)
            && !(issue_fire && bus.issue_rd == ADDR_WIDTH'(i))
            && cnt[i] != 2'd0) begin
          cnt[i] <= cnt[i] - 2'd1;
        end
      end
    end
  end

  assign unres = wen_q & (cnt[waddr_q] == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (unres || (bus.issue_valid && !issue_ok)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: reservations, arbitration,
// write latency, x0 handling, error flag and reset abort.
module tb_rf_writeback;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clk;
  logic rst;

  int passed;
  int total;

  rf_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rf_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.exu_valid   = 1'b0;
    bus.exu_rd      = '0;
    bus.exu_data    = '0;
    bus.lsu_valid   = 1'b0;
    bus.lsu_rd      = '0;
    bus.lsu_data    = '0;
  endtask

  initial begin
    logic any_busy;
    passed = 0;
    total  = 0;
    idle();
    bus.chk_addr1 = '0;
    bus.chk_addr2 = '0;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_wen", 32'(bus.rf_wen), 32'd0);
    chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    any_busy = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.chk_addr1 = AW'(i);
      bus.chk_addr2 = AW'(31 - i);
      #1;
      any_busy = any_busy | bus.chk_busy1 | bus.chk_busy2;
    end
    chk("rst_busy_all", 32'(any_busy), 32'd0);

    // Issue rd=5, EXU result two cycles later
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd5;
    tick();
    idle();
    bus.chk_addr1 = 5'd5;
    #1;
    chk("r5_busy_after_issue", 32'(bus.chk_busy1), 32'd1);
    tick();
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd5;
    bus.exu_data  = 32'hDEADBEEF;
    #1;
    chk("r5_exu_ready", 32'(bus.exu_ready), 32'd1);
    tick();
    idle();
    #1;
    chk("r5_wen", 32'(bus.rf_wen), 32'd1);
    chk("r5_waddr", 32'(bus.rf_waddr), 32'd5);
    chk("r5_wdata", bus.rf_wdata, 32'hDEADBEEF);
    chk("r5_busy_in_wen", 32'(bus.chk_busy1), 32'd1);
    tick();
    chk("r5_wen_off", 32'(bus.rf_wen), 32'd0);
    chk("r5_busy_clear", 32'(bus.chk_busy1), 32'd0);
    chk("r5_waddr_hold", 32'(bus.rf_waddr), 32'd5);

    // Simultaneous EXU/LSU: LSU first
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd3;
    tick();
    bus.issue_rd    = 5'd7;
    tick();
    idle();
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd3;
    bus.exu_data  = 32'h3333_0003;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd7;
    bus.lsu_data  = 32'h7777_0007;
    #1;
    chk("arb_exu_ready_low", 32'(bus.exu_ready), 32'd0);
    chk("arb_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    chk("arb_w1_waddr", 32'(bus.rf_waddr), 32'd7);
    chk("arb_w1_wdata", bus.rf_wdata, 32'h7777_0007);
    chk("arb_exu_ready_high", 32'(bus.exu_ready), 32'd1);
    tick();
    idle();
    chk("arb_w2_wen", 32'(bus.rf_wen), 32'd1);
    chk("arb_w2_waddr", 32'(bus.rf_waddr), 32'd3);
    chk("arb_w2_wdata", bus.rf_wdata, 32'h3333_0003);
    tick();
    bus.chk_addr1 = 5'd3;
    bus.chk_addr2 = 5'd7;
    #1;
    chk("arb_busy3", 32'(bus.chk_busy1), 32'd0);
    chk("arb_busy7", 32'(bus.chk_busy2), 32'd0);
    chk("arb_err", 32'(bus.err), 32'd0);

    // Saturating reservation on rd=9
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd9;
    bus.chk_addr1   = 5'd9;
    tick();
    tick();
    tick();
    chk("r9_issue_ready_full", 32'(bus.issue_ready), 32'd0);
    tick();
    idle();
    #1;
    chk("r9_err_set", 32'(bus.err), 32'd1);
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd9;
    bus.exu_data  = 32'h9;
    tick();
    tick();
    chk("r9_busy_after_r1", 32'(bus.chk_busy1), 32'd1);
    tick();
    idle();
    #1;
    chk("r9_busy_after_r2", 32'(bus.chk_busy1), 32'd1);
    chk("r9_wen_r3", 32'(bus.rf_wen), 32'd1);
    tick();
    chk("r9_busy_after_r3", 32'(bus.chk_busy1), 32'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_err_clear", 32'(bus.err), 32'd0);

    // x0 result, then unreserved write
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd0;
    bus.exu_data  = 32'h1234;
    #1;
    chk("x0_exu_ready", 32'(bus.exu_ready), 32'd1);
    tick();
    idle();
    #1;
    chk("x0_no_wen", 32'(bus.rf_wen), 32'd0);
    tick();
    chk("x0_no_err", 32'(bus.err), 32'd0);
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd4;
    bus.exu_data  = 32'h44;
    tick();
    idle();
    #1;
    chk("unres_wen", 32'(bus.rf_wen), 32'd1);
    chk("unres_waddr", 32'(bus.rf_waddr), 32'd4);
    chk("unres_err_not_yet", 32'(bus.err), 32'd0);
    tick();
    chk("unres_err_set", 32'(bus.err), 32'd1);
    bus.chk_addr1 = 5'd4;
    #1;
    chk("unres_busy4", 32'(bus.chk_busy1), 32'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Issue and retire on rd=6 in the same cycle
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd6;
    bus.chk_addr1   = 5'd6;
    tick();
    idle();
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd6;
    bus.exu_data  = 32'h66;
    tick();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd6;
    #1;
    chk("r6_wen", 32'(bus.rf_wen), 32'd1);
    chk("r6_issue_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    idle();
    #1;
    chk("r6_busy_kept", 32'(bus.chk_busy1), 32'd1);
    chk("r6_err", 32'(bus.err), 32'd0);
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd6;
    bus.exu_data  = 32'h67;
    tick();
    idle();
    tick();
    chk("r6_busy_clear", 32'(bus.chk_busy1), 32'd0);
    chk("r6_err_final", 32'(bus.err), 32'd0);

    // Reset mid-flight drops pending write and reservation
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd10;
    bus.chk_addr1   = 5'd10;
    tick();
    idle();
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd10;
    bus.exu_data  = 32'hA0A0;
    rst = 1'b1;
    tick();
    idle();
    rst = 1'b0;
    #1;
    chk("abort_wen", 32'(bus.rf_wen), 32'd0);
    chk("abort_busy10", 32'(bus.chk_busy1), 32'd0);
    tick();
    chk("abort_wen_next", 32'(bus.rf_wen), 32'd0);
    chk("abort_err", 32'(bus.err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Writer-side companion of the integer register file.
- Accepts result handshakes from the execute unit (EXU) and the load/store unit (LSU) and serializes them onto the register file's single write port.
- Keeps a per-register pending-write scoreboard. Decode reserves destinations through it and checks source hazards against it.
- Sits between EXU/LSU and the register file write port (wen/waddr/wdata).

Parameters:
ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers, index 0 hardwired zero
DATA_WIDTH, 32, register data width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
issue_valid  in  1  decode reserves issue_rd this cycle
issue_rd  in  ADDR_WIDTH  destination being reserved
issue_ready  out  1  reservation can be accepted
exu_valid  in  1  EXU result valid
exu_ready  out  1  EXU result accepted when high with exu_valid
exu_rd  in  ADDR_WIDTH  EXU destination
exu_data  in  DATA_WIDTH  EXU result
lsu_valid  in  1  LSU load result valid
lsu_ready  out  1  LSU result accepted when high with lsu_valid
lsu_rd  in  ADDR_WIDTH  LSU destination
lsu_data  in  DATA_WIDTH  LSU result
rf_wen  out  1  register file write enable (registered)
rf_waddr  out  ADDR_WIDTH  register file write address (registered)
rf_wdata  out  DATA_WIDTH  register file write data (registered)
chk_addr1  in  ADDR_WIDTH  source 1 hazard query
chk_addr2  in  ADDR_WIDTH  source 2 hazard query
chk_busy1  out  1  source 1 has pending write
chk_busy2  out  1  source 2 has pending write
err  out  1  sticky protocol error

Behaviour:
- Reset values:
  - rf_wen=0, rf_waddr=0, rf_wdata=0, err=0.
  - All pending counters=0.
  - Reset applies on any edge with rst=1 and aborts any in-flight write. An accepted result whose write was not yet presented is discarded.
- Scoreboard:
  - One 2-bit pending counter per register index 1..2**ADDR_WIDTH-1. Index 0 has no counter and always reads 0.
  - Increment: issue_valid & issue_ready & issue_rd!=0.
  - Decrement: on the edge that ends a cycle with rf_wen=1.
  - Same register incremented and decremented in the same cycle: counter unchanged.
  - issue_ready = (issue_rd==0) | (cnt[issue_rd]!=3). It is combinational and never blocked by a retire in the same cycle.
  - chk_busyN = (chk_addrN!=0) & (cnt[chk_addrN]!=0). It is combinational.
  - chk_busyN stays 1 during the rf_wen cycle. Busy drops the cycle after the write edge, when the register file already holds the new value.
- Arbitration (one write per cycle):
  - lsu_ready = 1 always.
  - exu_ready = ~lsu_valid, so LSU has fixed priority.
  - Accepted result = LSU handshake if present, else EXU handshake.
- Write stage latency is one cycle:
  - An accept in cycle N drives rf_wen=1, rf_waddr=rd and rf_wdata=data in cycle N+1.
  - With no accept in cycle N, rf_wen=0 in N+1. rf_waddr and rf_wdata hold their previous values.
- x0 writes:
  - An accepted result with rd=0 completes its handshake but produces rf_wen=0.
  - It does not touch any counter and is not an error.
- Errors:
  - err is set when a write retires to a register whose counter is 0 (unreserved write). The counter stays 0 and does not wrap.
  - err is set when issue_valid=1 with issue_ready=0. The reservation is dropped.
  - err clears only on rst.
- Back-to-back:
  - Full throughput of one result per cycle on both sides.
  - A counter may go 1→2→1→0 across consecutive cycles with interleaved issue and retire.

Test Plan:
- Reset with rst=1 for 2 cycles → rf_wen=0, err=0, chk_busy1=chk_busy2=0 for every chk_addr; issue_ready=1.
- Issue rd=5, then EXU rd=5 data=0xDEADBEEF two cycles later → chk_busy1(addr 5)=1 from the cycle after issue; rf_wen=1, waddr=5, wdata=0xDEADBEEF one cycle after accept; busy=0 the cycle after that.
- Issue rd=3 and rd=7; exu_valid and lsu_valid asserted together (rd=3 / rd=7) → exu_ready=0; LSU rd=7 written first, EXU rd=3 written the next cycle; no err.
- Issue rd=9 three times → issue_ready=0 on the 4th attempt. Issuing anyway sets err=1 and the counter stays 3. Three retires to rd=9 bring busy to 0 only after the third.
- EXU result rd=0 data=0x1234 → exu_ready=1, rf_wen stays 0, err=0. EXU result rd=4 with no reservation → rf_wen=1, err=1 the cycle after the write.
- Issue rd=6 in the same cycle its previous write retires (count 1) → count stays 1 and chk_busy stays 1. Assert rst mid-flight → all busy=0 and the pending write is dropped.
